// File: rtl/iir_sos_pkg.sv
// rtl/iir_sos_pkg.sv - shared constants, FSM state type and coefficient quantizer for the biquad
package iir_sos_pkg;

    // Positions of each coefficient inside the coeff parameter array.
    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A0 = 3;
    localparam int A1 = 4;
    localparam int A2 = 5;

    // Number of multiply-accumulate terms per output sample.
    localparam int NTERMS = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_RND,
        S_OUT
    } state_t;

    // round(c * 2^ncfrac), half away from zero, clamped into a signed
    // (ncint+ncfrac)-bit range. Only evaluated at elaboration.
    function automatic int quantize(input real c, input int ncint, input int ncfrac);
        real s;
        int  q;
        int  qmax;
        int  qmin;
        s = c * (2.0 ** ncfrac);
        if (s >= 0.0) begin
            q = $rtoi(s + 0.5);
        end else begin
            q = -$rtoi(0.5 - s);
        end
        qmax = (1 << (ncint + ncfrac - 1)) - 1;
        qmin = -(1 << (ncint + ncfrac - 1));
        if (q > qmax) begin
            q = qmax;
        end
        if (q < qmin) begin
            q = qmin;
        end
        return q;
    endfunction

endpackage

// File: rtl/iir_sos_if.sv
// rtl/iir_sos_if.sv - sample stream bundle between the biquad and its producer/consumer
// master drives dv_in/d_in and receives dv_out/d_out; slave is the filter side.
interface iir_sos_if #(
    parameter int Ndint  = 3,
    parameter int Ndfrac = 22
);
    logic                           dv_in;
    logic signed [Ndint-1:-Ndfrac]  d_in;
    logic                           dv_out;
    logic signed [Ndint-1:-Ndfrac]  d_out;

    modport master (
        output dv_in,
        output d_in,
        input  dv_out,
        input  d_out
    );

    modport slave (
        input  dv_in,
        input  d_in,
        output dv_out,
        output d_out
    );
endinterface

// File: rtl/iir_sos_mac.sv
// rtl/iir_sos_mac.sv - single signed multiplier feeding a full-precision accumulator
// Ports: clk, rst_n (async active-low), i_clr (zero accumulator), i_en (add product),
//        i_a/i_b (signed operands), o_acc (accumulator value).
module iir_sos_mac #(
    parameter int AW   = 25,
    parameter int BW   = 18,
    parameter int ACCW = 46
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic signed [AW-1:0]   i_a,
    input  logic signed [BW-1:0]   i_b,
    output logic signed [ACCW-1:0] o_acc
);

    logic signed [AW+BW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  r_acc;

    assign w_prod     = i_a * i_b;
    // Headroom bits above the product keep the five-term sum from wrapping.
    assign w_prod_ext = {{(ACCW-AW-BW){w_prod[AW+BW-1]}}, w_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/iir_sos.sv
// rtl/iir_sos.sv - Direct Form I biquad, one time-shared MAC, five MAC cycles per sample
// Ports: clk, rst_n (async active-low), bus (slave: dv_in/d_in in, dv_out/d_out out).
// A sample strobed at edge k appears on d_out with dv_out high after edge k+6.
module iir_sos
    import iir_sos_pkg::*;
#(
    parameter int  Ndint  = 3,
    parameter int  Ndfrac = 22,
    parameter int  Ncint  = 4,
    parameter int  Ncfrac = 14,
    parameter real coeff [0:5] = '{0.0976310729378175, 0.195262145875635, 0.0976310729378175,
                                   1.0, -0.942809041582063, 0.333333333333333}
) (
    input  logic      clk,
    input  logic      rst_n,
    iir_sos_if.slave  bus
);

    localparam int DW   = Ndint + Ndfrac;
    localparam int CW   = Ncint + Ncfrac;
    localparam int ACCW = DW + CW + 3;
    localparam int QW   = ACCW - Ncfrac;

    // Feedback terms are stored pre-negated so every MAC cycle is an add.
    localparam int Q_B0  = quantize(coeff[B0], Ncint, Ncfrac);
    localparam int Q_B1  = quantize(coeff[B1], Ncint, Ncfrac);
    localparam int Q_B2  = quantize(coeff[B2], Ncint, Ncfrac);
    localparam int Q_NA1 = -quantize(coeff[A1], Ncint, Ncfrac);
    localparam int Q_NA2 = -quantize(coeff[A2], Ncint, Ncfrac);

    localparam logic signed [CW-1:0] C_B0  = Q_B0[CW-1:0];
    localparam logic signed [CW-1:0] C_B1  = Q_B1[CW-1:0];
    localparam logic signed [CW-1:0] C_B2  = Q_B2[CW-1:0];
    localparam logic signed [CW-1:0] C_NA1 = Q_NA1[CW-1:0];
    localparam logic signed [CW-1:0] C_NA2 = Q_NA2[CW-1:0];

    localparam logic signed [ACCW-1:0] HALF    = {{(ACCW-Ncfrac){1'b0}}, 1'b1, {(Ncfrac-1){1'b0}}};
    localparam logic signed [QW-1:0]   SAT_MAX = {{(QW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [QW-1:0]   SAT_MIN = {{(QW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic signed [DW-1:0]   r_x0;
    logic signed [DW-1:0]   r_x1;
    logic signed [DW-1:0]   r_x2;
    logic signed [DW-1:0]   r_y1;
    logic signed [DW-1:0]   r_y2;
    logic                   r_dv_out;
    logic signed [DW-1:0]   r_d_out;

    logic                   w_accept;
    logic                   w_mac_en;
    logic signed [DW-1:0]   w_a;
    logic signed [CW-1:0]   w_b;
    logic signed [ACCW-1:0] w_acc;
    logic signed [ACCW-1:0] w_rnd;
    logic signed [QW-1:0]   w_q;
    logic signed [DW-1:0]   w_sat;

    // New samples are taken only when no computation is in flight; the OUT
    // cycle also accepts so back-to-back samples at 7-cycle spacing work.
    assign w_accept = bus.dv_in && ((r_state == S_IDLE) || (r_state == S_OUT));
    assign w_mac_en = (r_state == S_MAC);

    always_comb begin
        w_a = r_x0;
        w_b = C_B0;
        case (r_cnt)
            3'd0: begin w_a = r_x0; w_b = C_B0;  end
            3'd1: begin w_a = r_x1; w_b = C_B1;  end
            3'd2: begin w_a = r_x2; w_b = C_B2;  end
            3'd3: begin w_a = r_y1; w_b = C_NA1; end
            3'd4: begin w_a = r_y2; w_b = C_NA2; end
            default: begin w_a = r_x0; w_b = C_B0; end
        endcase
    end

    iir_sos_mac #(
        .AW   (DW),
        .BW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_mac_en),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_acc (w_acc)
    );

    // Round once: add half an output LSB, then drop the coefficient fraction
    // bits (floor of a two's-complement value).
    assign w_rnd = w_acc + HALF;
    assign w_q   = w_rnd[ACCW-1:Ncfrac];

    always_comb begin
        w_sat = w_q[DW-1:0];
        if (w_q > SAT_MAX) begin
            w_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (w_q < SAT_MIN) begin
            w_sat = {1'b1, {(DW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_x0     <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_y1     <= '0;
            r_y2     <= '0;
            r_dv_out <= 1'b0;
            r_d_out  <= '0;
        end else begin
            r_dv_out <= 1'b0;
            case (r_state)
                S_IDLE, S_OUT: begin
                    if (w_accept) begin
                        r_x0    <= bus.d_in;
                        r_cnt   <= '0;
                        r_state <= S_MAC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MAC: begin
                    if (r_cnt == 3'(NTERMS - 1)) begin
                        r_state <= S_RND;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_RND: begin
                    r_d_out  <= w_sat;
                    r_dv_out <= 1'b1;
                    r_x1     <= r_x0;
                    r_x2     <= r_x1;
                    r_y1     <= w_sat;
                    r_y2     <= r_y1;
                    r_state  <= S_OUT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dv_out = r_dv_out;
    assign bus.d_out  = r_d_out;

endmodule

// File: tb/tb_iir_sos.sv
// tb/tb_iir_sos.sv - self-checking bench for iir_sos against a behavioural biquad model
module tb_iir_sos;

    localparam longint QB0  = 1600;
    localparam longint QB1  = 3199;
    localparam longint QB2  = 1600;
    localparam longint QA1  = -15447;
    localparam longint QA2  = 5461;
    localparam longint YMAX = 16777215;
    localparam longint YMIN = -16777216;
    localparam longint ONE  = 4194304;

    logic clk;
    logic rst_n;

    iir_sos_if #(.Ndint(3), .Ndfrac(22)) bus ();

    iir_sos dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: history of the ideal filter and the queue of outputs it owes.
    longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
    longint pend_due[$];
    longint pend_y[$];
    longint busy_until = 0;
    longint edge_n     = 0;
    longint last_y     = 0;
    int     accepted   = 0;
    int     n_out      = 0;
    longint outs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint model_step(input longint x);
        longint acc;
        longint r;
        acc = QB0 * x + QB1 * mx1 + QB2 * mx2 - QA1 * my1 - QA2 * my2;
        r   = (acc + 8192) >>> 14;
        if (r > YMAX) r = YMAX;
        else if (r < YMIN) r = YMIN;
        mx2 = mx1;
        mx1 = x;
        my2 = my1;
        my1 = r;
        return r;
    endfunction

    // Compare process: one check of dv_out and d_out per cycle, 1 time unit after the edge.
    always begin
        logic   exp_dv;
        longint y;
        longint act_d;
        @(posedge clk);
        #1;
        edge_n++;
        act_d = bus.d_out;
        if (!rst_n) begin
            mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
            pend_due.delete();
            pend_y.delete();
            busy_until = 0;
            last_y     = 0;
            chk("reset_dv_out", longint'(bus.dv_out), 0);
            chk("reset_d_out", act_d, 0);
        end else begin
            if (bus.dv_in && edge_n >= busy_until) begin
                y = model_step(longint'(bus.d_in));
                pend_due.push_back(edge_n + 6);
                pend_y.push_back(y);
                busy_until = edge_n + 7;
                accepted++;
            end
            exp_dv = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] == edge_n) begin
                exp_dv = 1'b1;
                last_y = pend_y.pop_front();
                void'(pend_due.pop_front());
            end
            chk("dv_out", longint'(bus.dv_out), longint'(exp_dv));
            chk("d_out", act_d, last_y);
            if (bus.dv_out) begin
                outs.push_back(act_d);
                n_out++;
            end
        end
    end

    task automatic send(input longint x);
        @(negedge clk);
        bus.dv_in = 1'b1;
        bus.d_in  = x[24:0];
        @(negedge clk);
        bus.dv_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic impulse_run(input string tag);
        outs.delete();
        send(ONE);
        repeat (19) send(0);
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, outs.size(), 20);
        if (outs.size() >= 3) begin
            chk({tag, "_y0"}, outs[0], 409600);
            chk({tag, "_y1"}, outs[1], 1205119);
            chk({tag, "_y2"}, outs[2], 1409273);
        end
    endtask

    initial begin
        longint mx, mn, d;
        real    ph, w;
        int     a0, n0;

        rst_n     = 1'b0;
        bus.dv_in = 1'b0;
        bus.d_in  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Impulse response from reset.
        impulse_run("imp");

        // Reset three cycles into a computation: sample is lost, outputs cleared.
        outs.delete();
        @(negedge clk);
        bus.dv_in = 1'b1;
        bus.d_in  = 25'd1234567;
        @(negedge clk);
        bus.dv_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_dv_out", outs.size(), 0);
        chk("midrst_d_out", longint'(bus.d_out), 0);
        impulse_run("imp_after_rst");

        // Extra strobe three cycles after a sample must be ignored.
        pulse_reset();
        outs.delete();
        @(negedge clk);
        bus.dv_in = 1'b1;
        bus.d_in  = 25'd2097152;
        @(negedge clk);
        bus.dv_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.dv_in = 1'b1;
        bus.d_in  = 25'd4194304;
        @(negedge clk);
        bus.dv_in = 1'b0;
        repeat (2) @(negedge clk);
        send(0);
        repeat (8) @(negedge clk);
        chk("extra_count", outs.size(), 2);
        if (outs.size() >= 2) begin
            chk("extra_y0", outs[0], 204800);
            chk("extra_y1", outs[1], 602560);
        end

        // Unit step settling.
        pulse_reset();
        outs.delete();
        repeat (200) send(ONE);
        repeat (3) @(negedge clk);
        chk("step_count", outs.size(), 200);
        if (outs.size() == 200) begin
            for (int i = 180; i < 200; i++) begin
                d = outs[i] - 4194960;
                chk("step_settle", longint'(d >= -2 && d <= 2), 1);
            end
        end

        // Positive full-scale step: clamps high, never negative.
        pulse_reset();
        outs.delete();
        repeat (60) send(YMAX);
        repeat (3) @(negedge clk);
        mx = YMIN;
        mn = YMAX;
        foreach (outs[i]) begin
            if (outs[i] > mx) mx = outs[i];
            if (outs[i] < mn) mn = outs[i];
        end
        chk("sat_pos_max", mx, YMAX);
        chk("sat_pos_nonneg", longint'(mn >= 0), 1);

        // Negative full-scale step: clamps low.
        pulse_reset();
        outs.delete();
        repeat (60) send(YMIN);
        repeat (3) @(negedge clk);
        mn = YMAX;
        foreach (outs[i]) begin
            if (outs[i] < mn) mn = outs[i];
        end
        chk("sat_neg_min", mn, YMIN);

        // Chirp at full rate; every output is checked by the compare process.
        pulse_reset();
        a0 = accepted;
        n0 = n_out;
        ph = 0.0;
        w  = 0.02;
        for (int i = 0; i < 80; i++) begin
            send(longint'($rtoi($sin(ph) * 4194304.0)));
            ph = ph + w;
            w  = w + 0.02;
        end
        repeat (3) @(negedge clk);
        chk("chirp_dv_count", longint'(n_out - n0), longint'(accepted - a0));
        chk("chirp_in_count", longint'(accepted - a0), 80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iir_sos.md
IIR_SOS -- requirements
Module: iir_sos

Interface
REQ-001 Parameter Ndint, default 3: integer bits of the signed data word, sign bit included.
REQ-002 Parameter Ndfrac, default 22: fraction bits of the data word. The data word is Ndint+Ndfrac bits wide, indexed [Ndint-1:-Ndfrac].
REQ-003 Parameter Ncint, default 4: integer bits of each signed quantized coefficient, sign bit included.
REQ-004 Parameter Ncfrac, default 14: fraction bits of each quantized coefficient.
REQ-005 Parameter coeff, real[0:5], default {0.0976310729378175, 0.195262145875635, 0.0976310729378175, 1.0, -0.942809041582063, 0.333333333333333}, ordered {b0,b1,b2,a0,a1,a2}.
REQ-006 clk  input  1  sole clock; all logic is rising-edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 dv_in  input  1  input-sample-valid strobe, one cycle per sample.
REQ-009 d_in  input  [Ndint-1:-Ndfrac]  signed two's-complement input sample.
REQ-010 dv_out  output  1  output-sample-valid strobe, one cycle per sample.
REQ-011 d_out  output  [Ndint-1:-Ndfrac]  signed output sample; held between strobes.

Function
REQ-012 The block implements one Direct Form I biquad: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
REQ-013 a0 is treated as 1.0 and is not used in arithmetic.
REQ-014 At elaboration, each coefficient is quantized to round(c·2^Ncfrac) as a signed (Ncint+Ncfrac)-bit constant. Round-half-away-from-zero is used.
REQ-015 Defaults quantize to b0=1600, b1=3199, b2=1600, a1=−15447, a2=5461.
REQ-016 Products and the accumulator are kept at full precision. Accumulator width is at least Ndint+Ndfrac+Ncint+Ncfrac+3 bits, so no internal overflow occurs.
REQ-017 The sum is rounded once to Ndfrac fraction bits by adding half an LSB and then truncating.
REQ-018 The rounded sum is then saturated to [−2^(Ndint+Ndfrac−1), 2^(Ndint+Ndfrac−1)−1]. Wrap-around is forbidden.
REQ-019 The saturated value is both d_out and the stored y[n-1] for the next sample.
REQ-020 Arithmetic is a single time-shared multiplier with five sequential MAC cycles per sample.
REQ-021 For dv_in sampled high at edge k, dv_out is high for exactly the one cycle following edge k+6, with the new d_out valid in that same cycle.
REQ-022 Minimum dv_in spacing is 7 cycles.
REQ-023 A dv_in that arrives while a computation is in progress is ignored: no state change and no dv_out.
REQ-024 The x and y history registers shift only when a sample completes.
REQ-025 Control FSM states: IDLE → MAC (5 cycles, one term each) → ROUND/SAT → OUT (assert dv_out) → IDLE.
REQ-026 While dv_in is low, d_out holds its last value.

Reset
REQ-027 rst_n low asynchronously clears dv_out, d_out, x[n-1], x[n-2], y[n-1], y[n-2] and the accumulator to 0, and forces the FSM to IDLE.
REQ-028 Reset asserted mid-computation aborts that sample; no dv_out is produced for it.
REQ-029 After rst_n deasserts, the first dv_in is accepted at the next rising edge.

Structure
REQ-030 Shared package iir_sos_pkg holds the coefficient-index constants (B0..A2) and a function that quantizes a real coefficient to a signed integer, given Ncint and Ncfrac.
REQ-031 One sub-module, iir_sos_mac, holds the signed multiplier and accumulator with clear/enable controls.
REQ-032 iir_sos holds the FSM, history registers, rounding and saturation.

Verification
REQ-033 Impulse: after reset, one sample d_in = 2^22 (1.0), then zeros every 7 cycles. Required d_out sequence starts 409600, 1205119, 1409273, with each dv_out 6 cycles after its dv_in.
REQ-034 Unit step: d_in = 2^22 every 7 cycles. d_out settles to 4194960 ±2 LSB after 200 samples, with no oscillation after settling.
REQ-035 Saturation: step of d_in = 2^24−1. During overshoot d_out clamps at 16777215 and never goes negative. A step of −2^24 clamps at −16777216.
REQ-036 Reset mid-operation: rst_n pulsed low 3 cycles after a dv_in. That sample produces no dv_out, d_out = 0, and the next impulse reproduces REQ-033 exactly.
REQ-037 Throughput: a chirp of sin(phase)·2^22 at one sample per 7 cycles is compared against a bit-true fixed-point reference model. All outputs match exactly, and dv_out count equals dv_in count.
REQ-038 Extra dv_in: a second dv_in asserted 3 cycles after the first is ignored. Only one dv_out is produced, and history is unchanged by the ignored strobe.
